// File: rtl/mem_data_lsu.sv
// Load/store initiator for the data side of the dual-port simulation memory.
// Takes one request from execute, issues the memory read or write in the
// accept cycle, formats the load data and holds the response until it is taken.
// Misaligned or illegal-size requests never reach memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; memory strobes driven straight from it
// RD_WAIT | read issued last cycle; read data arrives this cycle
// RESP    | response presented, held stable until iRespReady
module mem_data_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqWr,
  input  logic [ADDR_WIDTH-1:0] iReqAddr,
  input  logic [DATA_WIDTH-1:0] iReqData,
  input  logic [1:0]            iReqSize,
  input  logic                  iReqSigned,
  output logic                  oRespValid,
  input  logic                  iRespReady,
  output logic [DATA_WIDTH-1:0] oRespData,
  output logic                  oRespMisalign,
  output logic                  pMemData_pRd_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pRd_bAddr,
  input  logic [DATA_WIDTH-1:0] pMemData_pRd_bData,
  output logic                  pMemData_pWr_bEn,
  output logic [ADDR_WIDTH-1:0] pMemData_pWr_bAddr,
  output logic [DATA_WIDTH-1:0] pMemData_pWr_bData,
  output logic                  pMemData_pWr_bMask_0,
  output logic                  pMemData_pWr_bMask_1,
  output logic                  pMemData_pWr_bMask_2,
  output logic                  pMemData_pWr_bMask_3
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t                state_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic                  resp_valid_q;
  logic                  resp_mis_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  logic                  accept;
  logic                  req_misalign;
  logic                  rd_go;
  logic                  wr_go;
  logic [DATA_WIDTH-1:0] store_data;
  logic [DATA_WIDTH-1:0] load_fmt_d;

  // Alignment rule: halves on even bytes, words on 4-byte boundaries, size 3 never legal.
  always_comb begin
    req_misalign = 1'b0;
    case (iReqSize)
      2'd1:    req_misalign = iReqAddr[0];
      2'd2:    req_misalign = |iReqAddr[1:0];
      2'd3:    req_misalign = 1'b1;
      default: req_misalign = 1'b0;
    endcase
  end

  // Ready is withheld during reset so no strobe can fire while iReset is high.
  assign oReqReady = (state_q == S_IDLE) & ~iReset;
  assign accept    = iReqValid & oReqReady;
  assign rd_go     = accept & ~iReqWr & ~req_misalign;
  assign wr_go     = accept &  iReqWr & ~req_misalign;

  // Store data keeps only the bytes covered by the access size.
  always_comb begin
    store_data = '0;
    case (iReqSize)
      2'd0:    store_data[7:0]  = iReqData[7:0];
      2'd1:    store_data[15:0] = iReqData[15:0];
      default: store_data       = iReqData;
    endcase
  end

  assign pMemData_pRd_bEn     = rd_go;
  assign pMemData_pRd_bAddr   = rd_go ? iReqAddr : '0;
  assign pMemData_pWr_bEn     = wr_go;
  assign pMemData_pWr_bAddr   = wr_go ? iReqAddr : '0;
  assign pMemData_pWr_bData   = wr_go ? store_data : '0;
  // m3 covers the low byte; masks grow towards m0 with size.
  assign pMemData_pWr_bMask_3 = wr_go;
  assign pMemData_pWr_bMask_2 = wr_go & (iReqSize != 2'd0);
  assign pMemData_pWr_bMask_1 = wr_go & (iReqSize == 2'd2);
  assign pMemData_pWr_bMask_0 = wr_go & (iReqSize == 2'd2);

  // Extend the low byte/half of the read data according to the latched request.
  always_comb begin
    load_fmt_d = pMemData_pRd_bData;
    case (size_q)
      2'd0: load_fmt_d = {{(DATA_WIDTH-8){signed_q & pMemData_pRd_bData[7]}},
                          pMemData_pRd_bData[7:0]};
      2'd1: load_fmt_d = {{(DATA_WIDTH-16){signed_q & pMemData_pRd_bData[15]}},
                          pMemData_pRd_bData[15:0]};
      default: load_fmt_d = pMemData_pRd_bData;
    endcase
  end

  // Request/response sequencing with registered response outputs.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q      <= S_IDLE;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_mis_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (req_misalign || iReqWr) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_mis_q   <= req_misalign;
              resp_data_q  <= '0;
            end else begin
              state_q  <= S_RD_WAIT;
              size_q   <= iReqSize;
              signed_q <= iReqSigned;
            end
          end
        end
        S_RD_WAIT: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_mis_q   <= 1'b0;
          resp_data_q  <= load_fmt_d;
        end
        S_RESP: begin
          if (iRespReady) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_mis_q   <= 1'b0;
            resp_data_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oRespValid    = resp_valid_q;
  assign oRespMisalign = resp_mis_q;
  assign oRespData     = resp_data_q;

endmodule
